// File: rtl/rxuart.sv
// Asynchronous 8N1 serial receiver: synchronises the line, checks the start bit,
// samples eight LSB-first data bits mid-bit and presents bytes on a valid/ready register.
module rxuart #(
  parameter int unsigned CLOCKS_PER_BAUD = 104
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned CW   = $clog2(CLOCKS_PER_BAUD);
  localparam int unsigned HALF = CLOCKS_PER_BAUD / 2;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BAUD = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Two-flop synchroniser; both stages idle high so reset never looks like a start bit.
  logic sync1_q;
  logic rx_s_q;

  state_t        state_q,     state_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [2:0]    bit_idx_q,   bit_idx_d;
  logic [7:0]    shift_q,     shift_d;
  logic [7:0]    data_q,      data_d;
  logic          valid_q,     valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q,   overrun_d;

  logic cnt_zero;
  logic deliver;

  assign cnt_zero = (cnt_q == '0);

  // NOTE: reset is synchronous (only i_clk in the sensitivity list), and every
  // sequential assignment is non-blocking so all flops update together.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end

      S_START: begin
        if (cnt_zero) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            cnt_d     = CNT_BAUD;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_zero) begin
          // Shift right so the first bit received ends up at the LSB.
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = CNT_BAUD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_zero) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_WAIT_HIGH: begin
        // Hold off until a break condition ends so it cannot look like a new start bit.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A same-cycle accept frees the holding register for the new byte.
    if (deliver) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: doc/rxuart.md
# rxuart

Asynchronous 8N1 serial receiver: the receive-side counterpart of the transmit path (`txuart`). It synchronises the incoming `i_uart_rx` line, validates the start bit, samples eight data bits LSB-first at mid-bit and checks the stop bit. It presents each byte on a valid/ready holding register for a downstream consumer, such as a loopback to `txuart` or a command parser. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLOCKS_PER_BAUD`, default 104 (12 MHz / 115200). Clock cycles per bit; must be ≥ 4. Half-bit count `H = CLOCKS_PER_BAUD/2`, floor.
- `i_clk`  input  1  system clock; all logic on posedge.
- `i_reset_n`  input  1  reset, synchronous, active-low.
- `i_uart_rx`  input  1  asynchronous serial line; idle high.
- `i_ready`  input  1  consumer accepts `o_data` when `o_valid & i_ready`.
- `o_data`  output  8  received byte; stable while `o_valid` is high.
- `o_valid`  output  1  byte available; held until accepted.
- `o_busy`  output  1  high in any state other than IDLE.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `o_overrun`  output  1  one-cycle pulse when a completed byte is dropped.

## Operation
- **Input synchroniser:** two-flop synchroniser on `i_uart_rx`; both flops reset to 1. All decisions use the second flop (`rx_s`).
- **IDLE:** on `rx_s == 0`, go to START and load the counter with `H-1`.
- **START:** decrement the counter. When it reaches 0, check `rx_s`:
  - `rx_s == 0`: go to DATA, load counter `CLOCKS_PER_BAUD-1`, set bit index to 0.
  - `rx_s == 1` (glitch): return to IDLE with no flags.
- **DATA:** each time the counter reaches 0:
  - shift `rx_s` into the MSB of the shift register (shift right); this places bit 0 at the LSB after 8 shifts;
  - reload the counter and increment the bit index;
  - after the 8th sample, go to STOP with the counter reloaded.
- **STOP:** when the counter reaches 0, sample `rx_s`:
  - `rx_s == 1`: deliver the byte (rules below), then go to IDLE.
  - `rx_s == 0`: pulse `o_frame_err`, do not deliver, go to WAIT_HIGH.
- **WAIT_HIGH:** remain until `rx_s == 1`, then go to IDLE. This blocks re-triggering during a break condition.
- **Delivery, `o_valid == 0`:** load `o_data` and set `o_valid`.
- **Delivery, `o_valid == 1` with `i_ready == 1` in the same cycle:** load the new byte; `o_valid` stays high.
- **Delivery, `o_valid == 1` with `i_ready == 0`:** the new byte is dropped, `o_data` keeps the old byte, `o_overrun` pulses.
- **Acceptance with no delivery:** `o_valid & i_ready` clears `o_valid` on the next edge.
- **Counter width:** `$clog2(CLOCKS_PER_BAUD)`. The bit index is 3 bits.

## Timing
- **Reset values:** state IDLE, `o_data` = 8'h00, `o_valid` = 0, `o_busy` = 0, `o_frame_err` = 0, `o_overrun` = 0, synchroniser = 1, counter = 0.
- **Reset mid-frame:** discards the partial byte and any pending `o_valid`. No flag pulses.
- **Edge numbering:** edge 0 is the first posedge that registers `i_uart_rx == 0` into sync flop 1.
  - Edge 2: IDLE→START.
  - Edge `2+H`: start-bit check.
  - Data bit *n* sampled at edge `2+H+(n+1)*CLOCKS_PER_BAUD`.
  - Stop bit sampled at edge `2+H+9*CLOCKS_PER_BAUD`. `o_valid`, or `o_frame_err`/`o_overrun`, is registered on that edge.
- **`o_busy`:** rises at edge 2 and falls on the edge that enters IDLE.
- **Back-to-back frames:** a start edge arriving one cycle after stop-bit sampling is accepted. There is no dead time beyond the synchroniser.
- **Flag pulses:** `o_frame_err` and `o_overrun` are high for exactly one cycle. They are mutually exclusive.

## Test plan
Use `CLOCKS_PER_BAUD = 8` (H = 4) and a bit period of 8 clocks for all scenarios.
- **Single byte:** send 0xA5 with `i_ready` = 0. Expect `o_valid` high from edge 78 and `o_data` = 0xA5, held stable. `o_busy` is low after edge 78. Pulsing `i_ready` for one cycle clears `o_valid` on the next edge.
- **Start glitch:** drive `i_uart_rx` low for 2 clocks, then high. Expect `o_busy` high for edges 2..6 and back in IDLE. No `o_valid` and no flags.
- **Framing error:** send 0x3C with the stop bit low, and hold the line low for 40 more clocks. Expect one `o_frame_err` pulse at edge 78 and no `o_valid`. `o_busy` stays high until 2 clocks after the line returns high.
- **Overrun and simultaneous accept:**
  - Send 0x11 then 0x22 back-to-back with `i_ready` = 0. Expect `o_data` = 0x11 retained and one `o_overrun` pulse at the second stop sample.
  - Repeat with `i_ready` = 1 only on that edge. Expect `o_data` = 0x22, `o_valid` still 1, and no `o_overrun`.
- **Reset mid-frame:** assert `i_reset_n` = 0 for 1 cycle during bit 3 of 0xFF. Expect all outputs at their reset values. A subsequent 0x5A is then received correctly.
- **Loopback:** feed `txuart` output at a matching baud rate for the 256 byte values. Expect every byte received unchanged, with no flags.
